// File: rtl/me_frame_scheduler.sv
// Frame-level controller for the ME core.
// Walks a frame of 8x8 blocks in raster order and gates the core enable.
// Captures one (MSAD, column, row) result per block into a 2-entry FIFO,
// tags each result with its block coordinates and keeps a saturating frame SAD.
//
// Handshake: a result moves downstream on every rising edge where
// mv_valid_o && mv_ready_i. mv_valid_o never depends on mv_ready_i.
// While mv_valid_o is high and mv_ready_i is low, the mv_* payload holds steady.
module me_frame_scheduler #(
  parameter int FRAME_W_BLK   = 4,
  parameter int FRAME_H_BLK   = 4,
  parameter int SAD_BIT_WIDTH = 14,
  parameter int FSAD_W        = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     me_en_o,
  input  logic                     me_valid_i,
  input  logic [SAD_BIT_WIDTH-1:0] me_msad_i,
  input  logic [4:0]               me_col_i,
  input  logic [4:0]               me_row_i,
  output logic                     mv_valid_o,
  input  logic                     mv_ready_i,
  output logic [7:0]               mv_blk_x_o,
  output logic [7:0]               mv_blk_y_o,
  output logic [4:0]               mv_col_o,
  output logic [4:0]               mv_row_o,
  output logic [SAD_BIT_WIDTH-1:0] mv_sad_o,
  output logic [FSAD_W-1:0]        frame_sad_o,
  output logic                     overflow_o,
  output logic [1:0]               dbg_state_o
);

  localparam int NBLK = FRAME_W_BLK * FRAME_H_BLK;
  localparam int EW   = 8 + 8 + 5 + 5 + SAD_BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [15:0]           r_cap_cnt;
  logic [7:0]            r_blk_x;
  logic [7:0]            r_blk_y;
  logic [FSAD_W-1:0]     r_frame_sad;
  logic                  r_overflow;

  logic [EW-1:0]         r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_cap;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_flush;
  logic [EW-1:0]         w_entry;
  logic [EW-1:0]         w_head;
  logic [FSAD_W:0]       w_sum;
  logic [FSAD_W-1:0]     w_sad_next;

  // A capture only happens in RUN; abort takes priority and discards it.
  assign w_cap   = me_valid_i && (r_state == RUN) && !abort_i;
  assign w_full  = (r_count == 2'd2);
  assign w_pop   = (r_count != 2'd0) && mv_ready_i;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push  = w_cap && (!w_full || w_pop);
  assign w_drop  = w_cap && w_full && !w_pop;
  assign w_flush = abort_i && (r_state != IDLE);
  assign w_entry = {r_blk_x, r_blk_y, me_col_i, me_row_i, me_msad_i};

  // Frame SAD with one guard bit; a carry out clamps to all-ones.
  assign w_sum      = {1'b0, r_frame_sad} + {{(FSAD_W + 1 - SAD_BIT_WIDTH){1'b0}}, me_msad_i};
  assign w_sad_next = w_sum[FSAD_W] ? {FSAD_W{1'b1}} : w_sum[FSAD_W-1:0];

  // Frame control FSM together with block counters, frame SAD and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cap_cnt   <= '0;
      r_blk_x     <= '0;
      r_blk_y     <= '0;
      r_frame_sad <= '0;
      r_overflow  <= 1'b0;
    end else if (w_flush) begin
      // Abandon the frame; frame SAD and overflow keep their values for inspection.
      r_state   <= IDLE;
      r_cap_cnt <= '0;
      r_blk_x   <= '0;
      r_blk_y   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state     <= RUN;
            r_cap_cnt   <= '0;
            r_blk_x     <= '0;
            r_blk_y     <= '0;
            r_frame_sad <= '0;
            r_overflow  <= 1'b0;
          end
        end
        RUN: begin
          if (w_cap) begin
            r_frame_sad <= w_sad_next;
            r_cap_cnt   <= r_cap_cnt + 16'd1;
            if (w_drop) r_overflow <= 1'b1;
            if (r_blk_x == 8'(FRAME_W_BLK - 1)) begin
              r_blk_x <= '0;
              r_blk_y <= r_blk_y + 8'd1;
            end else begin
              r_blk_x <= r_blk_x + 8'd1;
            end
            if (r_cap_cnt == 16'(NBLK - 1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_count == 2'd0) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Two-entry result FIFO; contents are cleared on reset so mv_* read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign me_en_o     = (r_state == RUN) && (r_count < 2'd2) && !abort_i;
  assign mv_valid_o  = (r_count != 2'd0);
  assign mv_blk_x_o  = w_head[EW-1 -: 8];
  assign mv_blk_y_o  = w_head[EW-9 -: 8];
  assign mv_col_o    = w_head[SAD_BIT_WIDTH+9 -: 5];
  assign mv_row_o    = w_head[SAD_BIT_WIDTH+4 -: 5];
  assign mv_sad_o    = w_head[SAD_BIT_WIDTH-1:0];
  assign frame_sad_o = r_frame_sad;
  assign overflow_o  = r_overflow;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler: a 2x2 frame instance (24-bit frame SAD)
// and a second 2x2 instance with an 8-bit frame SAD for the saturation case.
module tb_me_frame_scheduler;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: 2x2 frame, default widths
  logic        start_i = 0, abort_i = 0, me_valid_i = 0, mv_ready_i = 0;
  logic [13:0] me_msad_i = '0;
  logic [4:0]  me_col_i = '0, me_row_i = '0;
  logic        busy_o, done_o, me_en_o, mv_valid_o, overflow_o;
  logic [7:0]  mv_blk_x_o, mv_blk_y_o;
  logic [4:0]  mv_col_o, mv_row_o;
  logic [13:0] mv_sad_o;
  logic [23:0] frame_sad_o;
  logic [1:0]  dbg_state_o;

  me_frame_scheduler #(.FRAME_W_BLK(2), .FRAME_H_BLK(2), .SAD_BIT_WIDTH(14), .FSAD_W(24)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .me_en_o(me_en_o),
    .me_valid_i(me_valid_i), .me_msad_i(me_msad_i), .me_col_i(me_col_i), .me_row_i(me_row_i),
    .mv_valid_o(mv_valid_o), .mv_ready_i(mv_ready_i),
    .mv_blk_x_o(mv_blk_x_o), .mv_blk_y_o(mv_blk_y_o), .mv_col_o(mv_col_o), .mv_row_o(mv_row_o),
    .mv_sad_o(mv_sad_o), .frame_sad_o(frame_sad_o), .overflow_o(overflow_o),
    .dbg_state_o(dbg_state_o)
  );

  // instance B: 8-bit frame SAD for saturation
  logic        start_b = 0, valid_b = 0;
  logic [7:0]  msad_b = '0;
  logic        busy_b, done_b, en_b, mv_valid_b, ovf_b;
  logic [7:0]  blk_x_b, blk_y_b, sad_b, fsad_b;
  logic [4:0]  col_b, row_b;
  logic [1:0]  state_b;

  me_frame_scheduler #(.FRAME_W_BLK(2), .FRAME_H_BLK(2), .SAD_BIT_WIDTH(8), .FSAD_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(1'b0),
    .busy_o(busy_b), .done_o(done_b), .me_en_o(en_b),
    .me_valid_i(valid_b), .me_msad_i(msad_b), .me_col_i(5'd0), .me_row_i(5'd0),
    .mv_valid_o(mv_valid_b), .mv_ready_i(1'b1),
    .mv_blk_x_o(blk_x_b), .mv_blk_y_o(blk_y_b), .mv_col_o(col_b), .mv_row_o(row_b),
    .mv_sad_o(sad_b), .frame_sad_o(fsad_b), .overflow_o(ovf_b),
    .dbg_state_o(state_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one capture pulse on instance A
  task automatic capture(input logic [13:0] sad, input logic [4:0] col, input logic [4:0] row);
    me_valid_i = 1; me_msad_i = sad; me_col_i = col; me_row_i = row;
    tick();
    me_valid_i = 0;
  endtask

  initial begin
    // reset
    #2;
    tick(); tick();
    rst = 0;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_en", me_en_o, 0);
    check("rst_mv_valid", mv_valid_o, 0);
    check("rst_mv_sad", mv_sad_o, 0);
    check("rst_fsad", frame_sad_o, 0);
    check("rst_ovf", overflow_o, 0);

    // me_valid_i in IDLE is ignored
    me_valid_i = 1; me_msad_i = 14'd99;
    tick();
    me_valid_i = 0;
    check("idle_valid_busy", busy_o, 0);
    check("idle_valid_mv", mv_valid_o, 0);
    check("idle_valid_fsad", frame_sad_o, 0);

    // full frame, downstream always ready
    mv_ready_i = 1;
    start_i = 1; tick(); start_i = 0;
    check("t1_state_run", dbg_state_o, 1);
    check("t1_en", me_en_o, 1);
    for (int k = 0; k < 4; k++) begin
      capture(14'(10 * (k + 1)), 5'(k), 5'(k + 1));
      check("t1_mv_valid", mv_valid_o, 1);
      check("t1_blk_x", mv_blk_x_o, k % 2);
      check("t1_blk_y", mv_blk_y_o, k / 2);
      check("t1_sad", mv_sad_o, 10 * (k + 1));
      check("t1_col", mv_col_o, k);
      check("t1_row", mv_row_o, k + 1);
      if (k < 3) begin
        tick();
        check("t1_popped", mv_valid_o, 0);
      end
    end
    check("t1_drain", dbg_state_o, 2);
    check("t1_en_drain", me_en_o, 0);
    check("t1_fsad", frame_sad_o, 100);
    check("t1_no_early_done", done_o, 0);
    tick();
    check("t1_empty", mv_valid_o, 0);
    check("t1_still_drain", done_o, 0);
    tick();
    check("t1_done", done_o, 1);
    check("t1_done_busy", busy_o, 1);
    tick();
    check("t1_done_pulse", done_o, 0);
    check("t1_idle", busy_o, 0);
    check("t1_fsad_hold", frame_sad_o, 100);

    // backpressure and overflow
    mv_ready_i = 0;
    start_i = 1; tick(); start_i = 0;
    check("t2_fsad_clr", frame_sad_o, 0);
    capture(14'd5, 5'd3, 5'd4);
    check("t2_en_one", me_en_o, 1);
    capture(14'd6, 5'd1, 5'd1);
    check("t2_en_full", me_en_o, 0);
    check("t2_no_ovf", overflow_o, 0);
    capture(14'd7, 5'd2, 5'd2);
    check("t2_ovf", overflow_o, 1);
    check("t2_head_sad", mv_sad_o, 5);
    check("t2_head_x", mv_blk_x_o, 0);
    check("t2_head_col", mv_col_o, 3);
    check("t2_head_row", mv_row_o, 4);
    check("t2_fsad", frame_sad_o, 18);
    mv_ready_i = 1;
    tick();
    check("t2_second_sad", mv_sad_o, 6);
    check("t2_second_x", mv_blk_x_o, 1);
    check("t2_second_y", mv_blk_y_o, 0);
    tick();
    check("t2_empty", mv_valid_o, 0);
    check("t2_en_back", me_en_o, 1);

    // abort from RUN holds frame SAD and overflow
    abort_i = 1; tick(); abort_i = 0;
    check("t3_busy", busy_o, 0);
    check("t3_done", done_o, 0);
    check("t3_ovf_hold", overflow_o, 1);
    check("t3_fsad_hold", frame_sad_o, 18);

    // abort after one capture, then restart
    mv_ready_i = 0;
    start_i = 1; tick(); start_i = 0;
    check("t4_ovf_clr", overflow_o, 0);
    capture(14'd9, 5'd0, 5'd0);
    check("t4_one", mv_valid_o, 1);
    abort_i = 1; tick(); abort_i = 0;
    check("t4_abort_mv", mv_valid_o, 0);
    check("t4_abort_busy", busy_o, 0);
    check("t4_abort_done", done_o, 0);
    check("t4_fsad_hold", frame_sad_o, 9);
    start_i = 1; tick(); start_i = 0;
    capture(14'd11, 5'd5, 5'd6);
    check("t4_restart_x", mv_blk_x_o, 0);
    check("t4_restart_y", mv_blk_y_o, 0);
    check("t4_restart_sad", mv_sad_o, 11);

    // start while busy does nothing
    start_i = 1; tick(); start_i = 0;
    check("t5_state", dbg_state_o, 1);
    check("t5_fsad", frame_sad_o, 11);
    check("t5_head", mv_sad_o, 11);

    // simultaneous capture and pop on a full FIFO
    capture(14'd12, 5'd0, 5'd0);
    check("t6_full_en", me_en_o, 0);
    mv_ready_i = 1;
    capture(14'd13, 5'd0, 5'd0);
    check("t6_head_sad", mv_sad_o, 12);
    check("t6_head_x", mv_blk_x_o, 1);
    check("t6_no_ovf", overflow_o, 0);
    capture(14'd14, 5'd0, 5'd0);
    check("t6_drain", dbg_state_o, 2);
    check("t6_head13", mv_sad_o, 13);
    check("t6_head13_y", mv_blk_y_o, 1);
    check("t6_valid", mv_valid_o, 1);
    check("t6_fsad", frame_sad_o, 50);
    check("t6_no_ovf2", overflow_o, 0);

    // reset in DRAIN with a full FIFO
    mv_ready_i = 0;
    rst = 1; tick(); rst = 0;
    check("t7_busy", busy_o, 0);
    check("t7_mv_valid", mv_valid_o, 0);
    check("t7_sad", mv_sad_o, 0);
    check("t7_blk_y", mv_blk_y_o, 0);
    check("t7_fsad", frame_sad_o, 0);

    // saturation on the 8-bit accumulator
    start_b = 1; tick(); start_b = 0;
    valid_b = 1; msad_b = 8'd200; tick();
    check("t8_first", fsad_b, 200);
    tick(); valid_b = 0;
    check("t8_sat", fsad_b, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
